// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-fetch handshake, control inputs and PC status between the sequencer and its neighbours.
interface pc_sequencer_if #(
  parameter int Index_width = 9,
  parameter int Count_width = 16
);
  logic                   stall;
  logic                   branch_taken;
  logic [Index_width-1:0] branch_target;
  logic                   jump;
  logic [Index_width-1:0] jump_target;
  logic                   halt;
  logic                   resume;
  logic                   imem_req;
  logic [Index_width-1:0] imem_addr;
  logic                   imem_ready;
  logic [Index_width-1:0] pc;
  logic [Index_width-1:0] pc_plus4;
  logic                   trap;
  logic [Count_width-1:0] retire_count;
  logic [1:0]             state;
  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, halt, resume, imem_ready,
    output imem_req, imem_addr, pc, pc_plus4, trap, retire_count, state
  );
  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, halt, resume, imem_ready,
    input  imem_req, imem_addr, pc, pc_plus4, trap, retire_count, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs the FETCH/EXEC handshake and picks the next PC on each commit.
module pc_sequencer #(
  parameter int                     Index_width  = 9,
  parameter logic [Index_width-1:0] Reset_vector = '0,
  parameter logic [Index_width-1:0] Trap_vector  = 'h1F0,
  parameter int                     Count_width  = 16
) (
  input logic              clk,
  input logic              reset_n,
  pc_sequencer_if.master   bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;
  logic [1:0]             r_state;
  logic [Index_width-1:0] r_pc;
  logic                   r_trap;
  logic [Count_width-1:0] r_count;
  logic [Index_width-1:0] w_pc_plus4;
  logic [Index_width-1:0] w_cand;
  logic                   w_misaligned;
  assign w_pc_plus4   = r_pc + Index_width'(4);
  assign w_cand       = bus.jump ? bus.jump_target : bus.branch_taken ? bus.branch_target : w_pc_plus4;
  assign w_misaligned = |w_cand[1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= Reset_vector;
      r_trap  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: r_state <= bus.imem_ready ? S_EXEC : S_FETCH;
        S_EXEC: if (!bus.stall) begin
          r_count <= r_count + Count_width'(1);
          if (bus.halt) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_HALTED;
          end else begin
            r_pc    <= w_misaligned ? Trap_vector : w_cand;
            r_trap  <= r_trap | w_misaligned;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= bus.resume ? S_FETCH : S_HALTED;
      endcase
    end
  end
  // imem_req decodes the async-reset state register, so it drops the moment reset asserts
  assign bus.imem_req     = (r_state == S_FETCH);
  assign bus.imem_addr    = r_pc;
  assign bus.pc           = r_pc;
  assign bus.pc_plus4     = w_pc_plus4;
  assign bus.trap         = r_trap;
  assign bus.retire_count = r_count;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus randomized traffic, checked against an arithmetic reference model.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_pc, m_st, m_cnt;
  bit   m_trap;
  pc_sequencer_if bus ();
  pc_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic set_in(input bit rdy, input bit stl, input bit br, input int bt,
                        input bit jmp, input int jt, input bit hlt, input bit res);
    bus.imem_ready    = rdy;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_target = bt[8:0];
    bus.jump          = jmp;
    bus.jump_target   = jt[8:0];
    bus.halt          = hlt;
    bus.resume        = res;
  endtask
  task automatic model_reset();
    m_pc = 0; m_st = 0; m_cnt = 0; m_trap = 0;
  endtask
  task automatic check_all();
    chk("state", bus.state, m_st);
    chk("pc", bus.pc, m_pc);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc_plus4", bus.pc_plus4, (m_pc + 4) % 512);
    chk("imem_req", bus.imem_req, m_st == 1);
    chk("trap", bus.trap, m_trap);
    chk("retire_count", bus.retire_count, m_cnt);
  endtask
  task automatic step();
    int t;
    @(posedge clk);
    if (!reset_n) model_reset();
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (bus.imem_ready) m_st = 2;
    end else if (m_st == 2) begin
      if (!bus.stall) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (bus.halt) begin
          m_pc = (m_pc + 4) % 512;
          m_st = 3;
        end else begin
          t = bus.jump ? int'(bus.jump_target) : bus.branch_taken ? int'(bus.branch_target) : (m_pc + 4) % 512;
          if (t % 4 != 0) begin
            m_pc = 'h1F0;
            m_trap = 1;
          end else m_pc = t;
          m_st = 1;
        end
      end
    end else if (bus.resume) m_st = 1;
    #1;
    check_all();
  endtask
  function automatic int rnd_target();
    int t = int'($urandom_range(0, 511));
    return ($urandom % 4 != 0) ? (t & 'h1FC) : t;
  endfunction
  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_cnt", bus.retire_count, 0);
    chk("rst_trap", bus.trap, 0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("seq_pc0", bus.pc, 'h000);
    step();
    chk("exec_req", bus.imem_req, 0);
    step();
    chk("seq_pc1", bus.pc, 'h004);
    step();
    step();
    chk("seq_pc2", bus.pc, 'h008);
    step();
    step();
    chk("seq_cnt3", bus.retire_count, 3);
    step();
    step();
    chk("ws_pc", bus.pc, 'h010);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_req", bus.imem_req, 1);
      chk("ws_addr", bus.imem_addr, 'h010);
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("ws_commit", bus.pc, 'h014);
    step();
    set_in(1, 0, 0, 0, 1, 'h020, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(1, 0, 1, 'h080, 1, 'h100, 0, 0);
    step();
    chk("jmp_pri_pc", bus.pc, 'h100);
    chk("jmp_pri_trap", bus.trap, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(1, 1, 1, 'h0C2, 1, 'h0C3, 1, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.pc, 'h100);
      chk("stall_cnt", bus.retire_count, 7);
    end
    set_in(1, 0, 1, 'h0C2, 0, 0, 0, 0);
    step();
    chk("mis_pc", bus.pc, 'h1F0);
    chk("mis_trap", bus.trap, 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("sticky_trap", bus.trap, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req", bus.imem_req, 0);
    chk("arst_pc", bus.pc, 0);
    chk("arst_state", bus.state, 0);
    chk("arst_cnt", bus.retire_count, 0);
    chk("arst_trap", bus.trap, 0);
    @(negedge clk) reset_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_in(1, 0, 0, 0, 1, 'h1FC, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("wrap_pc", bus.pc, 'h000);
    chk("wrap_trap", bus.trap, 0);
    step();
    set_in(1, 0, 0, 0, 1, 'h040, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(1, 0, 1, 'h0C2, 1, 'h080, 1, 0);
    step();
    chk("halt_state", bus.state, 3);
    chk("halt_pc", bus.pc, 'h044);
    set_in(1, 1, 1, 'h0C2, 1, 'h0C1, 1, 0);
    step();
    step();
    chk("halted_hold", bus.pc, 'h044);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("resume_state", bus.state, 1);
    chk("resume_addr", bus.imem_addr, 'h044);
    for (int i = 0; i < 500; i++) begin
      set_in($urandom % 3 != 0, $urandom % 4 == 0, $urandom % 3 == 0, rnd_target(),
             $urandom % 4 == 0, rnd_target(), $urandom % 12 == 0, $urandom % 4 == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
